// File: rtl/uart.sv
// 8E1 UART with internal TxD->RxD loopback and selectable baud; Tx_BUSY rises the cycle after a write,
// Rx flags update at the mid-stop sample; writes while busy or with Tx_EN low are dropped (no queueing).

module uart_baud #(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       run,
  input  logic [2:0] baud_select,
  output logic       tick
);
  function automatic int calc_div(input int baud);
    return (CLK_FREQ + OVERSAMPLE * baud / 2) / (OVERSAMPLE * baud);
  endfunction

  localparam int DIV_MAX = calc_div(300);
  localparam int DW      = $clog2(DIV_MAX + 1);

  logic [DW-1:0] div_sel, div_q, cnt;

  always_comb begin
    case (baud_select)
      3'd0:    div_sel = DW'(calc_div(300));
      3'd1:    div_sel = DW'(calc_div(1200));
      3'd2:    div_sel = DW'(calc_div(4800));
      3'd3:    div_sel = DW'(calc_div(9600));
      3'd4:    div_sel = DW'(calc_div(19200));
      3'd5:    div_sel = DW'(calc_div(38400));
      3'd6:    div_sel = DW'(calc_div(57600));
      default: div_sel = DW'(calc_div(115200));
    endcase
  end

  assign tick = run && (cnt == div_q - DW'(1));

  // Held at zero while idle so every frame starts on a fresh, freshly reloaded period.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (!run || tick) begin
      cnt   <= '0;
      div_q <= div_sel;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end
endmodule

module uart #(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_WR,
  input  logic       Tx_EN,
  input  logic [7:0] Tx_DATA,
  input  logic       Rx_EN,
  output logic       Tx_BUSY,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_VALID,
  output logic [7:0] Rx_DATA
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int            TW   = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);

  state_t        tx_state, rx_state;
  logic          txd, loop_line, tx_tick, rx_tick;
  logic [7:0]    tx_sh, rx_sh;
  logic          tx_par, rx_par;
  logic [TW-1:0] tx_ticks, rx_ticks;
  logic [2:0]    tx_bits, rx_bits;
  logic          rx_s1, rx_s2, rx_prev;

  assign loop_line = txd;

  uart_baud #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OVERSAMPLE)) tx_baud (
    .Clk(Clk), .reset(reset), .run(Tx_BUSY), .baud_select(baud_select), .tick(tx_tick)
  );
  uart_baud #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OVERSAMPLE)) rx_baud (
    .Clk(Clk), .reset(reset), .run(rx_state != IDLE), .baud_select(baud_select), .tick(rx_tick)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      Tx_BUSY  <= 1'b0;
      txd      <= 1'b1;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_ticks <= '0;
      tx_bits  <= '0;
    end else if (tx_state == IDLE) begin
      if (Tx_WR && Tx_EN && !Tx_BUSY) begin
        tx_sh    <= Tx_DATA;
        tx_par   <= ^Tx_DATA;
        Tx_BUSY  <= 1'b1;
        txd      <= 1'b0;
        tx_ticks <= '0;
        tx_state <= START;
      end
    end else if (tx_tick) begin
      tx_ticks <= (tx_ticks == LAST) ? '0 : tx_ticks + TW'(1);
      if (tx_ticks == LAST) begin
        case (tx_state)
          START: begin
            txd      <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_bits  <= '0;
            tx_state <= DATA;
          end
          DATA: begin
            if (tx_bits == 3'd7) begin
              txd      <= tx_par;
              tx_state <= PARITY;
            end else begin
              txd     <= tx_sh[0];
              tx_sh   <= tx_sh >> 1;
              tx_bits <= tx_bits + 3'd1;
            end
          end
          PARITY: begin
            txd      <= 1'b1;
            tx_state <= STOP;
          end
          default: begin
            Tx_BUSY  <= 1'b0;
            tx_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Synchronizer flops reset to the idle level so reset release never looks like a start edge.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= IDLE;
      rx_sh     <= '0;
      rx_par    <= 1'b0;
      rx_ticks  <= '0;
      rx_bits   <= '0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
      Rx_VALID  <= 1'b0;
      Rx_DATA   <= 8'h00;
    end else begin
      rx_s1   <= loop_line;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (!Rx_EN) begin
        rx_state <= IDLE;
      end else if (rx_state == IDLE) begin
        if (rx_prev && !rx_s2) begin
          rx_ticks <= '0;
          rx_state <= START;
        end
      end else if (rx_tick) begin
        rx_ticks <= (rx_ticks == LAST) ? '0 : rx_ticks + TW'(1);
        if (rx_ticks == MID) begin
          case (rx_state)
            START: begin
              if (rx_s2) begin
                rx_state <= IDLE;
              end else begin
                Rx_VALID  <= 1'b0;
                Rx_PERROR <= 1'b0;
                Rx_FERROR <= 1'b0;
                rx_bits   <= '0;
                rx_state  <= DATA;
              end
            end
            DATA: begin
              rx_sh <= {rx_s2, rx_sh[7:1]};
              if (rx_bits == 3'd7) rx_state <= PARITY;
              else                 rx_bits  <= rx_bits + 3'd1;
            end
            PARITY: begin
              rx_par   <= rx_s2;
              rx_state <= STOP;
            end
            default: begin
              Rx_PERROR <= (rx_par != ^rx_sh);
              Rx_FERROR <= !rx_s2;
              Rx_VALID  <= (rx_par == ^rx_sh) && rx_s2;
              if ((rx_par == ^rx_sh) && rx_s2) Rx_DATA <= rx_sh;
              rx_state  <= IDLE;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart.sv
// Loopback UART bench: frame-level model checked every cycle plus directed literal checks.
module tb_uart;
  localparam int N_FAST   = 27;
  localparam int N_9600   = 326;
  localparam int SYNC_LAT = 3;
  localparam int GUARD    = 4;

  typedef struct {
    int         t;
    int         n;
    logic [7:0] d;
    int         kind;
  } frame_t;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] baud_select = 3'b111;
  logic       Tx_WR = 1'b0;
  logic       Tx_EN = 1'b1;
  logic [7:0] Tx_DATA = 8'h00;
  logic       Rx_EN = 1'b1;
  logic       Tx_BUSY, Rx_PERROR, Rx_FERROR, Rx_VALID;
  logic [7:0] Rx_DATA;

  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;
  int     cur_n = N_FAST;
  int     last_t = 0;
  bit     chk_en = 1'b0;
  frame_t frames[$];

  uart dut (
    .Clk(Clk), .reset(reset), .baud_select(baud_select), .Tx_WR(Tx_WR), .Tx_EN(Tx_EN),
    .Tx_DATA(Tx_DATA), .Rx_EN(Rx_EN), .Tx_BUSY(Tx_BUSY), .Rx_PERROR(Rx_PERROR),
    .Rx_FERROR(Rx_FERROR), .Rx_VALID(Rx_VALID), .Rx_DATA(Rx_DATA)
  );

  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs at cycle c, derived from the list of accepted frames: busy for 176
  // ticks after acceptance, flags clear at mid-start and settle at mid-stop.
  task automatic model_eval(input int c, output logic b, output logic v, output logic p,
                            output logic f, output logic [7:0] d, output logic g);
    b = 1'b0; v = 1'b0; p = 1'b0; f = 1'b0; d = 8'h00; g = 1'b0;
    foreach (frames[i]) begin
      int ts;
      int te;
      ts = frames[i].t + SYNC_LAT + 8 * frames[i].n;
      te = frames[i].t + SYNC_LAT + 168 * frames[i].n;
      if (c >= frames[i].t && c < frames[i].t + 176 * frames[i].n) b = 1'b1;
      if ((c - ts <= GUARD && ts - c <= GUARD) || (c - te <= GUARD && te - c <= GUARD)) g = 1'b1;
      if (c >= ts) begin v = 1'b0; p = 1'b0; f = 1'b0; end
      if (c >= te) begin
        case (frames[i].kind)
          0:       begin v = 1'b1; d = frames[i].d; end
          1:       p = 1'b1;
          default: f = 1'b1;
        endcase
      end
    end
  endtask

  always @(negedge Clk) begin
    logic eb, ev, ep, ef, eg;
    logic [7:0] ed;
    if (chk_en && !reset) begin
      model_eval(cyc, eb, ev, ep, ef, ed, eg);
      chk("model_busy", Tx_BUSY, eb);
      if (!eg) begin
        chk("model_valid", Rx_VALID, ev);
        chk("model_perror", Rx_PERROR, ep);
        chk("model_ferror", Rx_FERROR, ef);
        chk("model_data", Rx_DATA, ed);
      end
    end
  end

  // Called at a negedge; the write is sampled on the following rising edge.
  task automatic send(input logic [7:0] d, input int kind);
    logic b, v, p, f, g;
    logic [7:0] dd;
    model_eval(cyc, b, v, p, f, dd, g);
    Tx_DATA = d;
    Tx_WR   = 1'b1;
    last_t  = cyc + 1;
    if (Tx_EN && !b) frames.push_back('{t: last_t, n: cur_n, d: d, kind: kind});
    @(negedge Clk);
    Tx_WR = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge Clk);
  endtask

  task automatic wait_busy_low(input int bound);
    int k = 0;
    while (Tx_BUSY && k < bound) begin @(negedge Clk); k++; end
    if (Tx_BUSY) begin failures++; $display("FAIL busy_timeout: Tx_BUSY still 1 after %0d cycles", bound); end
  endtask

  task automatic wait_valid(input int bound);
    int k = 0;
    while (!Rx_VALID && k < bound) begin @(negedge Clk); k++; end
    if (!Rx_VALID) begin failures++; $display("FAIL valid_timeout: Rx_VALID still 0 after %0d cycles", bound); end
  endtask

  task automatic corrupt(input int t, input int bit_idx, input logic v);
    wait_cyc(t + (16 * bit_idx + 2) * cur_n);
    force dut.loop_line = v;
    wait_cyc(t + (16 * bit_idx + 14) * cur_n);
    release dut.loop_line;
  endtask

  initial begin
    int t1, t2, t3, t4, t5;
    repeat (4) @(negedge Clk);
    chk("rst_busy", Tx_BUSY, 1'b0);
    chk("rst_valid", Rx_VALID, 1'b0);
    chk("rst_perror", Rx_PERROR, 1'b0);
    chk("rst_ferror", Rx_FERROR, 1'b0);
    chk("rst_data", Rx_DATA, 8'h00);
    chk("rst_line", dut.loop_line, 1'b1);
    reset = 1'b0;
    @(negedge Clk);
    chk_en = 1'b1;

    send(8'h8A, 0); t1 = last_t;
    chk("busy_rise_8a", Tx_BUSY, 1'b1);
    wait_cyc(t1 + 100);
    send(8'hFF, 0);
    wait_cyc(t1 + 152 * cur_n);
    chk("parity_bit_8a", dut.loop_line, 1'b1);
    wait_busy_low(6000);
    chk("busy_len_8a", cyc - t1, 4752);
    chk("rx_valid_8a", Rx_VALID, 1'b1);
    chk("rx_data_8a", Rx_DATA, 8'h8A);

    send(8'hFF, 0); t2 = last_t;
    wait_cyc(t2 + 152 * cur_n);
    chk("parity_bit_ff", dut.loop_line, 1'b0);
    wait_valid(6000);
    chk("rx_data_ff", Rx_DATA, 8'hFF);
    chk("ff_before_190us", (cyc - t1) < 9500, 1'b1);
    wait_busy_low(6000);

    Tx_EN = 1'b0;
    send(8'h3C, 0);
    repeat (40) @(negedge Clk);
    chk("tx_en_blocks", Tx_BUSY, 1'b0);
    chk("tx_en_line_idle", dut.loop_line, 1'b1);
    Tx_EN = 1'b1;

    send(8'h5A, 1); t3 = last_t;
    corrupt(t3, 9, 1'b1);
    wait_busy_low(6000);
    chk("perr_flag", Rx_PERROR, 1'b1);
    chk("perr_valid", Rx_VALID, 1'b0);
    chk("perr_data_kept", Rx_DATA, 8'hFF);

    send(8'h33, 2); t4 = last_t;
    corrupt(t4, 10, 1'b0);
    wait_busy_low(6000);
    chk("ferr_flag", Rx_FERROR, 1'b1);
    chk("ferr_perror", Rx_PERROR, 1'b0);
    chk("ferr_valid", Rx_VALID, 1'b0);
    chk("ferr_data_kept", Rx_DATA, 8'hFF);

    baud_select = 3'b011;
    cur_n = N_9600;
    send(8'h55, 0); t5 = last_t;
    wait_cyc(t5 + 16 * cur_n);
    wait_valid(60000);
    chk("rx_data_9600", Rx_DATA, 8'h55);
    chk("rx_time_9600", (cyc - t5 >= 168 * 326) && (cyc - t5 <= 168 * 326 + 8), 1'b1);
    chk("busy_mid_9600", Tx_BUSY, 1'b1);

    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_busy", Tx_BUSY, 1'b0);
    chk("midrst_valid", Rx_VALID, 1'b0);
    chk("midrst_perror", Rx_PERROR, 1'b0);
    chk("midrst_ferror", Rx_FERROR, 1'b0);
    chk("midrst_data", Rx_DATA, 8'h00);
    chk("midrst_line", dut.loop_line, 1'b1);
    frames.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
